// File: rtl/spi_slave_rx_if.sv
// Bus bundle between an SPI master and the spi_slave_rx receiver.
// The master drives the serial pins; the receiver returns the captured word.
interface spi_slave_rx_if #(
    parameter int DATA_W = 12
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              err;

    modport master (output sclk, cs, mosi, input dout, done, err);
    modport slave  (input sclk, cs, mosi, output dout, done, err);
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: samples mosi LSB first on sclk rising edges
// and presents each complete DATA_W-bit frame on dout with a one-clk done pulse.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE, WAIT_CS} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    state_e                 state_q,   state_d;
    logic [DATA_W-1:0]      shift_q,   shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      dout_q,    dout_d;
    logic                   done_q,    done_d;
    logic                   err_q,     err_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                if (!cs_s) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    shift_d[bit_cnt_q] = mosi_s;
                    bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                        dout_d  = shift_d;
                        done_d  = 1'b1;
                    end
                end
                // The final sample wins over a simultaneous chip-select release.
                if (cs_s && state_d != DONE) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // cs resets to its inactive level so reset release never fakes a frame start.
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a behavioural SPI master drives frames
// and every received word is compared with the word the master sent.
module tb_spi_slave_rx;
    localparam int DATA_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int HALF_SCLK   = 5;

    logic clk;
    logic rst;

    spi_slave_rx_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc           = 0;
    int done_cnt      = 0;
    int err_cnt       = 0;
    int both_cnt      = 0;
    int last_done_cyc = 0;
    int last_rise_cyc = 0;
    logic [DATA_W-1:0] got_mem [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (bus.done) begin
            got_mem[done_cnt[7:0]] = bus.dout;
            done_cnt               = done_cnt + 1;
            last_done_cyc          = cyc;
        end
        if (bus.err) err_cnt = err_cnt + 1;
        if (bus.done && bus.err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master: drop cs, then clock out nbits of word LSB first at sclk = clk/10.
    task automatic send_bits(input logic [31:0] word, input int nbits, input bit cs_with_last);
        bus.cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = word[i];
            tick(HALF_SCLK);
            bus.sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) bus.cs = 1'b1;
            last_rise_cyc = cyc;
            tick(HALF_SCLK);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        tick(2);
        bus.cs = 1'b1;
        tick(12);
    endtask

    int base_done;
    int base_err;
    int lat;
    logic [DATA_W-1:0] exp_words [0:19];
    logic [DATA_W-1:0] prev_dout;
    logic [31:0]       w;

    initial begin
        rst      = 1'b1;
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset_dout", 32'(bus.dout), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_err",  32'(bus.err),  32'h0);
        tick(1);
        rst = 1'b0;
        tick(4);

        // Single known frame plus latency from the last sclk pin edge.
        base_done = done_cnt; base_err = err_cnt;
        send_bits(32'hA5C, 12, 1'b0);
        end_frame();
        check("single_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("single_err_cnt",  32'(err_cnt - base_err),   32'd0);
        check("single_dout",     32'(bus.dout),             32'hA5C);
        lat = last_done_cyc - last_rise_cyc;
        check("single_latency_ok", 32'(lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 3), 32'd1);

        // Back-to-back random frames, checked in order.
        base_done = done_cnt; base_err = err_cnt;
        for (int k = 0; k < 20; k++) begin
            exp_words[k] = DATA_W'($urandom);
            send_bits(32'(exp_words[k]), 12, 1'b0);
            end_frame();
        end
        check("rand_done_cnt", 32'(done_cnt - base_done), 32'd20);
        check("rand_err_cnt",  32'(err_cnt - base_err),   32'd0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("rand_word_%0d", k), 32'(got_mem[8'(base_done + k)]), 32'(exp_words[k]));
        end

        // Early abort after 7 bits: err once, dout untouched, then a clean frame.
        prev_dout = exp_words[19];
        base_done = done_cnt; base_err = err_cnt;
        send_bits(32'hFFF, 7, 1'b0);
        end_frame();
        check("abort_err_cnt",  32'(err_cnt - base_err),   32'd1);
        check("abort_done_cnt", 32'(done_cnt - base_done), 32'd0);
        check("abort_dout",     32'(bus.dout),             32'(prev_dout));
        send_bits(32'h123, 12, 1'b0);
        end_frame();
        check("after_abort_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("after_abort_dout",     32'(bus.dout),             32'h123);

        // Fourteen edges in one frame: only the first twelve bits count.
        base_done = done_cnt; base_err = err_cnt;
        w = 32'($urandom_range(0, 4095)) | (32'($urandom_range(0, 3)) << 12);
        send_bits(w, 14, 1'b0);
        end_frame();
        check("extra_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("extra_err_cnt",  32'(err_cnt - base_err),   32'd0);
        check("extra_dout",     32'(bus.dout),             w & 32'hFFF);

        // Reset after 5 bits discards the partial frame.
        base_done = done_cnt; base_err = err_cnt;
        send_bits(32'h0AB, 5, 1'b0);
        rst = 1'b1;
        tick(1);
        bus.cs = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(8);
        check("midrst_dout",     32'(bus.dout),             32'h0);
        check("midrst_done_cnt", 32'(done_cnt - base_done), 32'd0);
        check("midrst_err_cnt",  32'(err_cnt - base_err),   32'd0);
        send_bits(32'h3C3, 12, 1'b0);
        end_frame();
        check("after_rst_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("after_rst_dout",     32'(bus.dout),             32'h3C3);

        // cs released on the same pin edge as the 12th sclk rise.
        base_done = done_cnt; base_err = err_cnt;
        w = 32'($urandom_range(0, 4095));
        send_bits(w, 12, 1'b1);
        tick(12);
        check("simul_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("simul_err_cnt",  32'(err_cnt - base_err),   32'd0);
        check("simul_dout",     32'(bus.dout),             w);

        check("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, meaning the frame length in bits and the width of dout.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each of sclk, cs and mosi (legal values 2 or 3).
REQ-003 SHALL provide port clk, input, 1, the system clock; every flop in the block is clocked on its rising edge.
REQ-004 SHALL provide port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL provide port sclk, input, 1, the SPI serial clock from the master; it is asynchronous to clk and idles low.
REQ-006 SHALL provide port cs, input, 1, the active-low chip select from the master; it is asynchronous to clk.
REQ-007 SHALL provide port mosi, input, 1, the serial data from the master, sent LSB first.
REQ-008 SHALL provide port dout, output, DATA_W, the last complete received word.
REQ-009 SHALL provide port done, output, 1, a one-clk pulse marking a new word on dout.
REQ-010 SHALL provide port err, output, 1, a one-clk pulse marking a frame aborted by cs going high early.

Function
REQ-011 SHALL pass sclk, cs and mosi through SYNC_STAGES flops each before any use.
REQ-012 SHALL also register the synchronized sclk once more and detect a rising edge as sclk_sync=1 and sclk_prev=0.
- Call this signal sclk_rise.
- It is high for exactly one clk per sclk rising edge.
REQ-013 SHALL implement states IDLE, RECV, DONE and WAIT_CS.
REQ-014 IDLE: when synchronized cs=0, SHALL go to RECV, clear the shift register and set bit_cnt=0; sclk_rise in IDLE SHALL be ignored.
REQ-015 RECV: on sclk_rise, SHALL write synchronized mosi into shift[bit_cnt] (LSB first) and increment bit_cnt.
REQ-016 RECV: on the sclk_rise that samples bit DATA_W-1, SHALL go to DONE.
REQ-017 DONE: in the cycle after that last sample (cycle N+1 for a last-edge detect in cycle N):
- dout is loaded with the full word and done=1 for that cycle only;
- the next state is then WAIT_CS.
REQ-018 WAIT_CS: SHALL ignore all sclk_rise and return to IDLE only when synchronized cs=1; a new frame therefore needs cs to toggle high.
REQ-019 If synchronized cs=1 in RECV before bit DATA_W-1 is sampled:
- err=1 for one clk and the next state is IDLE;
- dout keeps its previous value and done is not asserted.
REQ-020 If the final sclk_rise and synchronized cs=1 occur in the same clk, the sample SHALL take priority: go to DONE, done=1, err=0.
REQ-021 dout SHALL hold its value between done pulses; it changes only in DONE.
REQ-022 done and err SHALL never be high in the same cycle.
REQ-023 bit_cnt SHALL be wide enough for DATA_W and SHALL never wrap inside a frame.
REQ-024 Correct capture SHALL be guaranteed when sclk high and low phases are each >= SYNC_STAGES+1 clk periods; mosi SHALL be stable from 1 clk before to SYNC_STAGES+1 clk after each sclk rising edge.
REQ-025 Latency from the last sclk pin rising edge to done SHALL be SYNC_STAGES+2 clk cycles (+/-1 for synchronizer phase).

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL reset as follows:
- state=IDLE, bit_cnt=0, shift=0;
- dout=0, done=0, err=0;
- every synchronizer flop: sclk 0, cs 1, mosi 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word with no done or err pulse.
REQ-028 After reset, a frame whose cs is already low SHALL still be accepted after sync latency; the first sclk edges may be lost.

Verification
REQ-029 Bench SHALL cover single frame: cs low, 12 bits of 12'hA5C LSB first at sclk=clk/10 -> done pulses once, dout=12'hA5C, err=0.
REQ-030 Bench SHALL cover 20 back-to-back random frames with cs toggled high >= 4 clk between frames -> 20 done pulses, each dout matching the master's din, in order.
REQ-031 Bench SHALL cover early abort: cs high after 7 bits of 12'hFFF -> err=1 for one clk, no done, dout unchanged from the prior value; the next frame 12'h123 is received correctly.
REQ-032 Bench SHALL cover extra clocks: 14 sclk edges with cs low -> exactly one done with the first 12 bits, edges 13-14 ignored, no err.
REQ-033 Bench SHALL cover reset mid-frame: rst=1 for 2 clk after 5 bits -> dout=0, no done or err, state IDLE; a following frame 12'h3C3 is received correctly.
REQ-034 Bench SHALL cover simultaneous events: cs rises in the same synchronized cycle as the 12th sclk_rise -> done=1, err=0, dout equals the sent word.
